// File: rtl/revo_word_scheduler.sv
// revo_word_scheduler
//
// Builds the revolution-marker word for the 8-bit OSERDES word input of the
// clock/revo generator. One revolution lasts period+1 word-clock cycles. At
// each revolution boundary a marker of programmable serial phase and width is
// placed into the word stream. Bit WIDTH-1 of a word is transmitted first.
// Marker bits that run past the end of a word spill into the first positions
// of the next word. Runs are either continuous or a fixed number of
// revolutions. A configuration offered while running is held, then applied at
// the next marker so that each revolution uses a single consistent config.
//
// Optional feature macro: REVO_WORD_SCHEDULER_REVOLUTION_COUNTER_EN
//   defined   -> revolution_count counts emitted markers; it wraps and clears
//                on reset and on a start accepted from IDLE
//   undefined -> revolution_count is tied to zero
//
// Ports:
//   clock                 word clock; all logic on its rising edge
//   reset                 synchronous, active-high
//   cfg_period_minus_one  words per revolution minus one
//   cfg_phase             serial position of the first marker bit
//   cfg_marker_width      marker length in bits (0 = none, >WIDTH clamps)
//   cfg_valid/cfg_ready   config handshake; ready is low while a config is held
//   start, stop           single-cycle run control (stop wins)
//   burst_count           revolutions per run, sampled at start (0 = forever)
//   revo_word             registered word to the OSERDES
//   revo_strobe           high in the cycle revo_word carries a marker start
//   busy                  scheduler is not idle
//   revolution_count      markers emitted since start (feature-dependent)

module revo_word_scheduler #(
    parameter int WIDTH                    = 8,
    parameter int COUNTER_WIDTH            = 11,
    parameter int DEFAULT_PERIOD_MINUS_ONE = 1279
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COUNTER_WIDTH-1:0]   cfg_period_minus_one,
    input  logic [$clog2(WIDTH)-1:0]   cfg_phase,
    input  logic [$clog2(WIDTH):0]     cfg_marker_width,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic                       start,
    input  logic                       stop,
    input  logic [15:0]                burst_count,
    output logic [WIDTH-1:0]           revo_word,
    output logic                       revo_strobe,
    output logic                       busy,
    output logic [31:0]                revolution_count
);

    localparam int PHASE_W = $clog2(WIDTH);
    localparam int MW_W    = PHASE_W + 1;
    localparam int SPAN    = 2 * WIDTH;
    localparam logic [SPAN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [15:0]              remaining;
    logic [WIDTH-1:0]         spill_pending;

    // Active configuration
    logic [COUNTER_WIDTH-1:0] act_period;
    logic [PHASE_W-1:0]       act_phase;
    logic [MW_W-1:0]          act_width;

    // Configuration held while running, applied at the next marker
    logic [COUNTER_WIDTH-1:0] pend_period;
    logic [PHASE_W-1:0]       pend_phase;
    logic [MW_W-1:0]          pend_width;
    logic                     pend_valid;

    // Effective configuration for a marker emitted this edge
    logic [COUNTER_WIDTH-1:0] eff_period;
    logic [PHASE_W-1:0]       eff_phase;
    logic [MW_W-1:0]          eff_width;
    logic [MW_W-1:0]          cfg_width_clamped;

    logic [SPAN-1:0]          marker_ones;
    logic [SPAN-1:0]          marker_bits;
    logic [WIDTH-1:0]         new_main;
    logic [WIDTH-1:0]         new_spill;
    int unsigned              marker_shift;

    assign cfg_ready = !pend_valid;
    assign busy      = (state != IDLE);

    always_comb begin
        cfg_width_clamped = cfg_marker_width;
        if (cfg_marker_width > MW_W'(WIDTH)) begin
            cfg_width_clamped = MW_W'(WIDTH);
        end
    end

    always_comb begin
        eff_period = act_period;
        eff_phase  = act_phase;
        eff_width  = act_width;
        if (pend_valid) begin
            eff_period = pend_period;
            eff_phase  = pend_phase;
            eff_width  = pend_width;
        end
    end

    // Two-word window: the upper half is the current word, the lower half the
    // next one. Serial position s maps to window bit SPAN-1-s, so a run of
    // eff_width ones is shifted up until its top bit sits at position phase.
    always_comb begin
        marker_shift = 32'(SPAN) - 32'(eff_phase) - 32'(eff_width);
        marker_ones  = ~(ALL_ONES << eff_width);
        marker_bits  = marker_ones << marker_shift;
        new_main     = marker_bits[SPAN-1:WIDTH];
        new_spill    = marker_bits[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            remaining     <= '0;
            spill_pending <= '0;
            revo_word     <= '0;
            revo_strobe   <= 1'b0;
            act_period    <= COUNTER_WIDTH'(DEFAULT_PERIOD_MINUS_ONE);
            act_phase     <= '0;
            act_width     <= MW_W'(WIDTH);
            pend_period   <= '0;
            pend_phase    <= '0;
            pend_width    <= '0;
            pend_valid    <= 1'b0;
        end else begin
            // Configuration intake. A config still held when the run ends
            // (stop before the next marker) is applied once back in IDLE.
            if (cfg_valid && !pend_valid) begin
                if (state == IDLE) begin
                    act_period <= cfg_period_minus_one;
                    act_phase  <= cfg_phase;
                    act_width  <= cfg_width_clamped;
                end else begin
                    pend_period <= cfg_period_minus_one;
                    pend_phase  <= cfg_phase;
                    pend_width  <= cfg_width_clamped;
                    pend_valid  <= 1'b1;
                end
            end else if (state == IDLE && pend_valid) begin
                act_period <= pend_period;
                act_phase  <= pend_phase;
                act_width  <= pend_width;
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    revo_word   <= '0;
                    revo_strobe <= 1'b0;
                    if (start && !stop) begin
                        state     <= RUN;
                        counter   <= '0;
                        remaining <= burst_count;
                    end
                end

                RUN: begin
                    if (stop) begin
                        // A spill still owed is sent from DRAIN, one cycle
                        // after the stop edge.
                        revo_word   <= '0;
                        revo_strobe <= 1'b0;
                        state       <= (spill_pending != '0) ? DRAIN : IDLE;
                    end else if (counter == '0) begin
                        revo_word     <= new_main | spill_pending;
                        spill_pending <= new_spill;
                        revo_strobe   <= 1'b1;
                        counter       <= eff_period;
                        if (pend_valid) begin
                            act_period <= pend_period;
                            act_phase  <= pend_phase;
                            act_width  <= pend_width;
                            pend_valid <= 1'b0;
                        end
                        if (remaining == 16'd1) begin
                            state <= (new_spill != '0) ? DRAIN : IDLE;
                        end else if (remaining != '0) begin
                            remaining <= remaining - 16'd1;
                        end
                    end else begin
                        revo_word     <= spill_pending;
                        spill_pending <= '0;
                        counter       <= counter - 1'b1;
                        revo_strobe   <= 1'b0;
                    end
                end

                DRAIN: begin
                    revo_word     <= spill_pending;
                    spill_pending <= '0;
                    revo_strobe   <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    revo_word     <= '0;
                    revo_strobe   <= 1'b0;
                    spill_pending <= '0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef REVO_WORD_SCHEDULER_REVOLUTION_COUNTER_EN
    logic [31:0] rev_count;

    // Counts at the same edge that raises revo_strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            rev_count <= '0;
        end else if (state == IDLE && start && !stop) begin
            rev_count <= '0;
        end else if (state == RUN && !stop && counter == '0) begin
            rev_count <= rev_count + 32'd1;
        end
    end

    assign revolution_count = rev_count;
`else
    assign revolution_count = '0;
`endif

endmodule

// File: tb/tb_revo_word_scheduler.sv
// Scoreboard bench for revo_word_scheduler. Each driven cycle pushes the
// word/strobe/busy expected after the coming rising edge; a monitor pops and
// compares shortly after every rising edge.

module tb_revo_word_scheduler;

    localparam int WIDTH = 8;
    localparam int CW    = 11;

`ifdef REVO_WORD_SCHEDULER_REVOLUTION_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [CW-1:0]     cfg_period_minus_one;
    logic [2:0]        cfg_phase;
    logic [3:0]        cfg_marker_width;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              start;
    logic              stop;
    logic [15:0]       burst_count;
    logic [WIDTH-1:0]  revo_word;
    logic              revo_strobe;
    logic              busy;
    logic [31:0]       revolution_count;

    typedef struct packed {
        logic [7:0] word;
        logic       strobe;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    revo_word_scheduler #(
        .WIDTH(WIDTH),
        .COUNTER_WIDTH(CW),
        .DEFAULT_PERIOD_MINUS_ONE(1279)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_period_minus_one(cfg_period_minus_one),
        .cfg_phase(cfg_phase),
        .cfg_marker_width(cfg_marker_width),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .start(start),
        .stop(stop),
        .burst_count(burst_count),
        .revo_word(revo_word),
        .revo_strobe(revo_strobe),
        .busy(busy),
        .revolution_count(revolution_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("revo_word", 32'(revo_word), 32'(e.word));
            check("revo_strobe", 32'(revo_strobe), 32'(e.strobe));
            check("busy", 32'(busy), 32'(e.busy));
        end
    end

    // Queue the expectation for the next rising edge, then wait for the
    // following falling edge where inputs are changed.
    task automatic tick(input logic [7:0] w, input logic s, input logic b);
        exp_t e;
        e.word   = w;
        e.strobe = s;
        e.busy   = b;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic offer_cfg(input logic [CW-1:0] p, input logic [2:0] ph, input logic [3:0] w);
        cfg_period_minus_one = p;
        cfg_phase            = ph;
        cfg_marker_width     = w;
        cfg_valid            = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        cfg_valid            = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        cfg_period_minus_one = '0;
        cfg_phase            = '0;
        cfg_marker_width     = '0;
        cfg_valid            = 1'b0;
        start                = 1'b0;
        stop                 = 1'b0;
        burst_count          = '0;
        @(negedge clock);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_rev_count", revolution_count, 32'd0);

        // Default config, continuous: FF marker every 1280 words
        burst_count = 16'd0;
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        tick(8'hFF, 1'b1, 1'b1);
        repeat (1279) tick(8'h00, 1'b0, 1'b1);
        tick(8'hFF, 1'b1, 1'b1);
        repeat (10) tick(8'h00, 1'b0, 1'b1);
        stop = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        stop = 1'b0;
        check("count_continuous", revolution_count, CNT_EN ? 32'd2 : 32'd0);
        tick(8'h00, 1'b0, 1'b0);

        // period 3, phase 6, width 4: 03, C0, 00, 00; then stop on a marker edge
        offer_cfg(11'd3, 3'd6, 4'd4);
        check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick(8'h03, 1'b1, 1'b1);
            tick(8'hC0, 1'b0, 1'b1);
            tick(8'h00, 1'b0, 1'b1);
            tick(8'h00, 1'b0, 1'b1);
        end
        stop = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        stop = 1'b0;
        tick(8'h00, 1'b0, 1'b0);

        // Burst of two with spill, ending through DRAIN
        offer_cfg(11'd1, 3'd5, 4'd5);
        burst_count = 16'd2;
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        burst_count = 16'd0;
        tick(8'h07, 1'b1, 1'b1);
        tick(8'hC0, 1'b0, 1'b1);
        tick(8'h07, 1'b1, 1'b1);
        tick(8'hC0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);

        // Config offered mid-revolution is held until the next marker
        offer_cfg(11'd3, 3'd0, 4'd8);
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        tick(8'hFF, 1'b1, 1'b1);
        tick(8'h00, 1'b0, 1'b1);
        cfg_period_minus_one = 11'd3;
        cfg_phase            = 3'd0;
        cfg_marker_width     = 4'd2;
        cfg_valid            = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        check("pending_ready_low", 32'(cfg_ready), 32'd0);
        tick(8'h00, 1'b0, 1'b1);
        check("pending_ready_held", 32'(cfg_ready), 32'd0);
        tick(8'hC0, 1'b1, 1'b1);
        check("pending_ready_back", 32'(cfg_ready), 32'd1);
        repeat (3) tick(8'h00, 1'b0, 1'b1);
        tick(8'hC0, 1'b1, 1'b1);
        stop = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        stop = 1'b0;

        // Period 0 with width clamp (15 -> 8) at phase 4; stop drains the spill
        offer_cfg(11'd0, 3'd4, 4'd15);
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        tick(8'h0F, 1'b1, 1'b1);
        tick(8'hFF, 1'b1, 1'b1);
        tick(8'hFF, 1'b1, 1'b1);
        stop = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        stop = 1'b0;
        tick(8'hF0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        tick(8'h00, 1'b0, 1'b0);

        // Reset with a spill and a held config outstanding
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        cfg_period_minus_one = 11'd5;
        cfg_phase            = 3'd0;
        cfg_marker_width     = 4'd1;
        cfg_valid            = 1'b1;
        tick(8'h0F, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        check("held_before_reset", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        check("midrun_reset_ready", 32'(cfg_ready), 32'd1);
        check("midrun_reset_count", revolution_count, 32'd0);

        // Defaults restored and held config discarded: single FF burst
        burst_count = 16'd1;
        start = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        start = 1'b0;
        tick(8'hFF, 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        check("count_single_burst", revolution_count, CNT_EN ? 32'd1 : 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/revo_word_scheduler.md
# revo_word_scheduler

Sequences the revolution-marker word fed to the 8-bit OSERDES word input of the clock/revo generator. Each revolution is a programmable number of word-clock cycles (quad-bunch slots at 127 MHz); the block places a marker of programmable bit phase and width into the serial stream. A marker crossing a word boundary spills into the next word. The block also supports continuous or N-revolution bursts and applies new configuration glitch-free at revolution boundaries.

## Interface
Parameters:
- WIDTH, 8, bits per serialized word; bit WIDTH-1 is transmitted first (serial position 0)
- COUNTER_WIDTH, 11, width of the words-per-revolution counter
- DEFAULT_PERIOD_MINUS_ONE, 1279, period loaded at reset (1280 words = 5120 bunches)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  word clock from the OSERDES wrapper; all logic on its rising edge
- reset  in  1  synchronous, active-high
- cfg_period_minus_one  in  COUNTER_WIDTH  words per revolution minus one
- cfg_phase  in  $clog2(WIDTH)  serial position of first marker bit (0 = first transmitted)
- cfg_marker_width  in  $clog2(WIDTH)+1  marker length in bits; 0 = no marker; values >WIDTH clamp to WIDTH
- cfg_valid  in  1  config offer
- cfg_ready  out  1  high when no config is pending
- start  in  1  single-cycle request to begin emitting
- stop  in  1  single-cycle request to halt
- burst_count  in  16  revolutions per run, sampled at start; 0 = continuous
- revo_word  out  WIDTH  registered word to the OSERDES
- revo_strobe  out  1  high for exactly the cycle revo_word carries a marker start
- busy  out  1  state != IDLE
- revolution_count  out  32  markers emitted (see Configuration)

## Operation
- Active config registers: period, phase, width. Reset values: DEFAULT_PERIOD_MINUS_ONE, 0, WIDTH.
- A config is accepted on cfg_valid & cfg_ready.
  - In IDLE it is copied to the active registers at that edge, and cfg_ready stays high.
  - In RUN it is held in a pending register, and cfg_ready drops. The pending config is applied at the next marker edge; that marker and the whole following revolution use the new values. cfg_ready returns high the following cycle.
- Marker bits cover serial positions phase … phase+width-1.
  - Positions up to WIDTH-1 go in the current word; bit = WIDTH-1-position.
  - The excess goes to positions 0 … (phase+width-WIDTH-1) of the next word, held in spill_pending.
- States:
  - IDLE: revo_word=0, counter held.
    - start & !stop → RUN, with counter=0 and remaining=burst_count.
  - RUN, each edge:
    - If counter==0: revo_word ← main | spill_pending, spill_pending ← new spill, revo_strobe ← 1, counter ← period.
      - If remaining==1 (non-continuous): go to DRAIN if new spill ≠ 0, else IDLE. Otherwise decrement remaining when nonzero.
    - Else: revo_word ← spill_pending, spill_pending ← 0, counter ← counter-1, revo_strobe ← 0.
    - stop: → DRAIN if spill_pending ≠ 0, else IDLE. stop takes precedence over a marker due at the same edge; no marker is emitted.
  - DRAIN: revo_word ← spill_pending, spill_pending ← 0, → IDLE.
- With period 0, every word is a marker word; spill is ORed with the next word's main bits.
- start while busy is ignored. When start and stop are both high, stop wins.
- Reset mid-operation: state IDLE, revo_word=0, revo_strobe=0, spill_pending=0, pending config discarded, active config to defaults, cfg_ready=1, revolution_count=0.

## Timing
- start sampled at edge t: the first marker is on revo_word after edge t+1, and revo_strobe is high in the same cycle.
- Marker-to-marker spacing is period+1 cycles.
- Spill word follows its marker by exactly 1 cycle.
- Outputs are registered; no combinational input-to-output path except cfg_ready, which is registered from pending state.
- After stop at edge t: revo_word=0 from edge t+1, or from t+2 when a spill is drained.

## Configuration
- Macro REVO_WORD_SCHEDULER_REVOLUTION_COUNTER_EN.
- Defined: revolution_count increments on every revo_strobe, wraps at 2^32, and clears on reset and on start accepted from IDLE.
- Undefined: no counter logic is built; revolution_count is tied to 0.

## Test plan
- Reset, then start with burst_count=0 and default config → revo_word=8'hFF every 1280 cycles, revo_strobe coincident, zeros in between.
- Config period=3, phase=6, width=4, then start → words 8'h03, 8'hC0, 8'h00, 8'h00 repeating.
- burst_count=2, period=1, phase=5, width=5 → 8'h07, 8'hC0 (spill), 8'h07, DRAIN 8'hC0, then 0; busy low after DRAIN.
- In RUN, offer config width=2 mid-revolution → cfg_ready low until the next marker; that marker is 8'hC0.
- Assert start and stop together in IDLE → stays IDLE. In RUN, assert stop on the cycle counter==0 → no strobe.
- Assert reset mid-revolution with a spill pending → next word 0, cfg_ready=1, and revolution_count=0 when the macro is defined.
